lcd_bus_arbiter: RTL and testbench



---
 rtl/lcd_pkg.sv | 40 ++++
 rtl/lcd_bus_arbiter_if.sv | 35 +++
 rtl/lcd_rr_arb2.sv | 15 +
 rtl/lcd_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and helpers for the LCD bus arbiter.
package lcd_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STATE_W = 3;

  // Bus sequencing states.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } lcd_bus_state_t;

  // One captured LCD write: register select plus data byte.
  typedef struct packed {
    logic              rs;
    logic [DATA_W-1:0] data;
  } lcd_byte_t;

  // HD44780 instruction bytes.
  localparam logic [DATA_W-1:0] CMD_CLEAR        = 8'h01;
  localparam logic [DATA_W-1:0] CMD_RETURN_HOME  = 8'h02;
  localparam logic [DATA_W-1:0] CMD_FUNCTION_SET = 8'h38;
  localparam logic [DATA_W-1:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [DATA_W-1:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [DATA_W-1:0] CMD_SET_LINE1    = 8'h80;
  localparam logic [DATA_W-1:0] CMD_SET_LINE2    = 8'hC0;

  // Clear (0x01) and return-home (0x02/0x03) need the long busy-wait.
  function automatic logic is_long_cmd(input logic rs, input logic [DATA_W-1:0] data);
    return (!rs) && (data[7:2] == 6'd0) && (data[1:0] != 2'b00);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Handshake and LCD pin bundle between two requesters, the arbiter and the panel.
//   req*/rs*/data*   : requester byte offer (driven by requesters)
//   ack*             : one-cycle capture pulse back to each requester
//   busy             : arbiter is mid-transaction
//   lcd_e/rs/rw/data : HD44780 parallel bus pins
interface lcd_bus_arbiter_if;
  import lcd_pkg::*;

  logic              req0;
  logic              rs0;
  logic [DATA_W-1:0] data0;
  logic              ack0;
  logic              req1;
  logic              rs1;
  logic [DATA_W-1:0] data1;
  logic              ack1;
  logic              busy;
  logic              lcd_e;
  logic              lcd_rs;
  logic              lcd_rw;
  logic [DATA_W-1:0] lcd_data;

  // Requester side: offers bytes, observes acks and the bus.
  modport master (
    output req0, rs0, data0, req1, rs1, data1,
    input  ack0, ack1, busy, lcd_e, lcd_rs, lcd_rw, lcd_data
  );

  // Arbiter side.
  modport slave (
    input  req0, rs0, data0, req1, rs1, data1,
    output ack0, ack1, busy, lcd_e, lcd_rs, lcd_rw, lcd_data
  );

endinterface

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin arbiter (combinational).
//   req[1:0]   : pending requests
//   last_grant : index of the requester granted most recently
//   gnt[1:0]   : one-hot grant, all-zero when nothing is requested
module lcd_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // On a tie the requester that was not granted last wins.
  assign gnt[0] = req[0] & (~req[1] |  last_grant);
  assign gnt[1] = req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780 8-bit bus between two requesters, sequencing RS/DATA/E
// with programmable setup, pulse, hold and post-write busy-wait times.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : requester handshakes, busy flag and LCD pins (slave side)
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned CNT_SETUP = 4,
  parameter int unsigned CNT_PULSE = 50,
  parameter int unsigned CNT_HOLD  = 4,
  parameter int unsigned CNT_SHORT = 5000,
  parameter int unsigned CNT_LONG  = 200_000
) (
  input  logic              clk,
  input  logic              reset,
  lcd_bus_arbiter_if.slave  bus
);

  localparam int unsigned CNT_MAX =
    max2(max2(max2(CNT_SETUP, CNT_PULSE), max2(CNT_HOLD, CNT_SHORT)), CNT_LONG);
  localparam int unsigned CNT_W = $clog2(CNT_MAX) + 1;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] RL_SETUP = CNT_W'(CNT_SETUP - 1);
  localparam logic [CNT_W-1:0] RL_PULSE = CNT_W'(CNT_PULSE - 1);
  localparam logic [CNT_W-1:0] RL_HOLD  = CNT_W'(CNT_HOLD - 1);
  localparam logic [CNT_W-1:0] RL_SHORT = CNT_W'(CNT_SHORT - 1);
  localparam logic [CNT_W-1:0] RL_LONG  = CNT_W'(CNT_LONG - 1);

  localparam logic [STATE_W-1:0] ST_IDLE  = IDLE;
  localparam logic [STATE_W-1:0] ST_SETUP = SETUP;
  localparam logic [STATE_W-1:0] ST_PULSE = PULSE;
  localparam logic [STATE_W-1:0] ST_HOLD  = HOLD;
  localparam logic [STATE_W-1:0] ST_WAIT  = WAIT;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  lcd_byte_t          byte_q, byte_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               busy_q, busy_d;
  logic               e_q, e_d;
  logic [1:0]         gnt;
  logic               cnt_zero;

  lcd_rr_arb2 u_arb (
    .req        ({bus.req1, bus.req0}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign cnt_zero = (cnt_q == '0);

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      byte_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      e_q          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      byte_q       <= byte_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      e_q          <= e_d;
    end
  end

  // Next-state and next-output logic; counter reloads on every state entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    byte_d       = byte_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    e_d          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          state_d      = ST_SETUP;
          cnt_d        = RL_SETUP;
          ack0_d       = gnt[0];
          ack1_d       = gnt[1];
          last_grant_d = gnt[1];
          byte_d.rs    = gnt[1] ? bus.rs1   : bus.rs0;
          byte_d.data  = gnt[1] ? bus.data1 : bus.data0;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_PULSE;
          cnt_d   = RL_PULSE;
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = RL_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          e_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_WAIT;
          cnt_d   = is_long_cmd(byte_q.rs, byte_q.data) ? RL_LONG : RL_SHORT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.busy     = busy_q;
  assign bus.lcd_e    = e_q;
  assign bus.lcd_rs   = byte_q.rs;
  assign bus.lcd_data = byte_q.data;
  assign bus.lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed self-checking bench for lcd_bus_arbiter with S=2, P=3, H=2, SHORT=5, LONG=20.
module tb_lcd_bus_arbiter;
  import lcd_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   both_hi = 0;

  always #5 clk = ~clk;

  lcd_bus_arbiter_if bus ();

  lcd_bus_arbiter #(
    .CNT_SETUP (2),
    .CNT_PULSE (3),
    .CNT_HOLD  (2),
    .CNT_SHORT (5),
    .CNT_LONG  (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.ack0 && bus.ack1) both_hi++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait up to limit edges for any ack; who = -1 on timeout.
  task automatic wait_ack(input int limit, output int who, output int t);
    int i;
    who = -1;
    t   = 0;
    i   = 0;
    while (who < 0 && i < limit) begin
      step();
      i++;
      if (bus.ack0 || bus.ack1) begin
        who = bus.ack1 ? 1 : 0;
        t   = cyc;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (bus.busy && i < 100) begin
      step();
      i++;
    end
    check(tag, 32'(bus.busy), 32'd0);
  endtask

  // Hold one requester high for two transactions of the same byte and check ack spacing.
  task automatic spacing(input string tag, input logic id, input logic rs,
                         input logic [7:0] d, input int exp);
    int w0, w1, t0, t1;
    if (id) begin
      bus.req1 = 1'b1; bus.rs1 = rs; bus.data1 = d;
    end else begin
      bus.req0 = 1'b1; bus.rs0 = rs; bus.data0 = d;
    end
    wait_ack(100, w0, t0);
    check({tag, "_who"}, 32'(w0), 32'(id));
    check({tag, "_bus"}, {23'd0, bus.lcd_rs, bus.lcd_data}, {23'd0, rs, d});
    wait_ack(100, w1, t1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check({tag, "_gap"}, 32'(t1 - t0), 32'(exp));
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] e_v, b_v, a_v;
    int bad, who, t, prev_t, acks1;
    int order[4];
    int times[4];
    logic [7:0] seen[4];

    bus.req0 = 1'b0; bus.rs0 = 1'b0; bus.data0 = 8'h00;
    bus.req1 = 1'b0; bus.rs1 = 1'b0; bus.data1 = 8'h00;
    reset = 1'b1;
    repeat (3) step();

    // Reset values.
    check("rst_e",    32'(bus.lcd_e),    32'd0);
    check("rst_rs",   32'(bus.lcd_rs),   32'd0);
    check("rst_data", 32'(bus.lcd_data), 32'd0);
    check("rst_rw",   32'(bus.lcd_rw),   32'd0);
    check("rst_ack",  {30'd0, bus.ack1, bus.ack0}, 32'd0);
    check("rst_busy", 32'(bus.busy),     32'd0);
    reset = 1'b0;
    repeat (3) step();

    // Test 1: single data write; k counts edges after the sampling edge.
    bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h41;
    e_v = '0; b_v = '0; a_v = '0; bad = 0;
    for (int k = 1; k <= 14; k++) begin
      step();
      e_v[k] = bus.lcd_e;
      b_v[k] = bus.busy;
      a_v[k] = bus.ack0;
      if (k == 1) bus.req0 = 1'b0;
      if (bus.lcd_data !== 8'h41 || bus.lcd_rs !== 1'b1) bad++;
    end
    check("t1_e",    32'(e_v), 32'h0038);
    check("t1_busy", 32'(b_v), 32'h1FFE);
    check("t1_ack",  32'(a_v), 32'h0002);
    check("t1_bus",  32'(bad), 32'd0);
    check("t1_rw",   32'(bus.lcd_rw), 32'd0);

    // Test 2: long vs short busy-wait, including decode boundaries.
    spacing("t2_clear", 1'b1, 1'b0, CMD_CLEAR,       28);
    spacing("t2_line1", 1'b1, 1'b0, CMD_SET_LINE1,   13);
    spacing("t2_home",  1'b0, 1'b0, CMD_RETURN_HOME, 28);
    spacing("t2_x03",   1'b1, 1'b0, 8'h03,           28);
    spacing("t2_x04",   1'b0, 1'b0, 8'h04,           13);
    spacing("t2_rs1",   1'b1, 1'b1, 8'h01,           13);

    // Test 3: both requesters held from reset -> alternating grants.
    reset = 1'b1;
    bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h30;
    bus.req1 = 1'b1; bus.rs1 = 1'b1; bus.data1 = 8'h31;
    step();
    reset = 1'b0;
    both_hi = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(100, who, t);
      order[i] = who;
      times[i] = t;
      seen[i]  = bus.lcd_data;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_who%0d", i), 32'(order[i]), 32'(i % 2));
      check($sformatf("t3_data%0d", i), 32'(seen[i]), (i % 2 == 0) ? 32'h30 : 32'h31);
    end
    for (int i = 1; i < 4; i++)
      check($sformatf("t3_gap%0d", i), 32'(times[i] - times[i-1]), 32'd13);
    wait_idle("t3_idle");
    check("t3_overlap", 32'(both_hi), 32'd0);

    // Test 4: req1 withdrawn while busy produces nothing.
    bus.req0 = 1'b1; bus.rs0 = 1'b0; bus.data0 = 8'h55;
    wait_ack(100, who, t);
    check("t4_who", 32'(who), 32'd0);
    bus.req0 = 1'b0;
    repeat (3) step();
    check("t4_busy", 32'(bus.busy), 32'd1);
    bus.req1 = 1'b1; bus.rs1 = 1'b1; bus.data1 = 8'hAA;
    step();
    bus.req1 = 1'b0;
    acks1 = 0;
    bad   = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (bus.ack1) acks1++;
      if (bus.lcd_data !== 8'h55 || bus.lcd_rs !== 1'b0) bad++;
    end
    check("t4_ack1", 32'(acks1), 32'd0);
    check("t4_bus",  32'(bad),   32'd0);

    // Test 5: reset during PULSE clears everything at once.
    bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h66;
    wait_ack(100, who, t);
    check("t5_who", 32'(who), 32'd0);
    step();
    step();
    check("t5_in_pulse", 32'(bus.lcd_e), 32'd1);
    bus.req1 = 1'b1; bus.rs1 = 1'b1; bus.data1 = 8'h77;
    #2 reset = 1'b1;
    #1;
    check("t5_e",    32'(bus.lcd_e),    32'd0);
    check("t5_data", 32'(bus.lcd_data), 32'd0);
    check("t5_rs",   32'(bus.lcd_rs),   32'd0);
    check("t5_busy", 32'(bus.busy),     32'd0);
    check("t5_ack",  {30'd0, bus.ack1, bus.ack0}, 32'd0);
    step();
    reset = 1'b0;
    wait_ack(100, who, t);
    check("t5_tie", 32'(who), 32'd0);
    check("t5_tie_data", 32'(bus.lcd_data), 32'h66);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle("t5_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
